// File: rtl/alink_dispatch_if.sv
// rtl/alink_dispatch_if.sv - TX dispatch / RX report handshake bundle for alink_dispatch
interface alink_dispatch_if #(
  parameter int PHY_NUM = 32
);
  logic               tx_task_vld;
  logic               tx_phy_start;
  logic [PHY_NUM-1:0] tx_phy_sel;
  logic               tx_phy_done;
  logic               rx_done;
  logic [PHY_NUM-1:0] rx_done_sel;

  // Dispatcher side: issues starts, watches task availability and completions
  modport master (
    output tx_phy_start, tx_phy_sel,
    input  tx_task_vld, tx_phy_done, rx_done, rx_done_sel
  );

  // FIFO / PHY side
  modport slave (
    input  tx_phy_start, tx_phy_sel,
    output tx_task_vld, tx_phy_done, rx_done, rx_done_sel
  );
endinterface

// File: rtl/alink_dispatch.sv
// rtl/alink_dispatch.sv - round-robin TX task dispatcher with per-channel busy timeout (option: ALINK_AUTO_MASK_EN)
module alink_dispatch #(
  parameter int PHY_NUM = 32,
  parameter int TOUT_W  = 32,
  parameter int PTR_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      reg_flush,
  input  logic [PHY_NUM-1:0]        reg_mask,
  input  logic [TOUT_W-1:0]         reg_tout,
  alink_dispatch_if.master          lnk,
  output logic [PHY_NUM-1:0]        reg_busy,
  output logic                      tout_vld,
  output logic [PHY_NUM-1:0]        tout_sel,
  output logic [TOUT_W*PHY_NUM-1:0] timer_cnt,
  output logic [PHY_NUM-1:0]        auto_mask,
  output logic [1:0]                cur_state
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1} state_t;

  state_t              state_q, state_d;
  logic                clr;
  logic [PTR_W-1:0]    rr_ptr, grant_q, grant_d;
  logic [PTR_W:0]      idx;
  logic                found;
  logic                go, finish;
  logic [PHY_NUM-1:0]  eligible;
  logic                start_q;
  logic [PHY_NUM-1:0]  sel_q;
  logic [PHY_NUM-1:0]  busy_q;
  logic [PHY_NUM-1:0]  tout_d;
  logic [TOUT_W-1:0]   timer_q [PHY_NUM];

  // Flush behaves exactly like reset and overrides everything else
  assign clr      = rst | reg_flush;
  assign eligible = ~reg_mask & ~busy_q & ~auto_mask;
  assign go       = (state_q == ST_IDLE) && lnk.tx_task_vld && found;
  assign finish   = (state_q == ST_SEND) && lnk.tx_phy_done;

  // Round-robin search from rr_ptr, wrapping at PHY_NUM rather than 2^PTR_W
  always_comb begin
    found   = 1'b0;
    grant_d = '0;
    idx     = '0;
    for (int k = 0; k < PHY_NUM; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(PHY_NUM)) idx = idx - (PTR_W+1)'(PHY_NUM);
      if (!found && eligible[idx[PTR_W-1:0]]) begin
        found   = 1'b1;
        grant_d = idx[PTR_W-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: grant moves to SEND, completion returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go) state_d = ST_SEND;
      ST_SEND: if (lnk.tx_phy_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Start pulse, held select, granted index and round-robin pointer
  always_ff @(posedge clk) begin
    if (clr) begin
      start_q <= 1'b0;
      sel_q   <= '0;
      grant_q <= '0;
      rr_ptr  <= '0;
    end else begin
      start_q <= go;
      if (go) begin
        sel_q   <= PHY_NUM'(1) << grant_d;
        grant_q <= grant_d;
      end else if (finish) begin
        sel_q  <= '0;
        rr_ptr <= (grant_q == PTR_W'(PHY_NUM-1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

  // Timeout fires only when the count expires without a same-cycle report
  always_comb begin
    tout_d = '0;
    for (int i = 0; i < PHY_NUM; i++) begin
      tout_d[i] = busy_q[i] && (timer_q[i] == TOUT_W'(1)) &&
                  !(lnk.rx_done && lnk.rx_done_sel[i]) &&
                  !(finish && (grant_q == PTR_W'(i)));
    end
  end

  // Per-channel busy/timer: completion load wins over report, report over expiry
  always_ff @(posedge clk) begin
    if (clr) begin
      busy_q   <= '0;
      tout_sel <= '0;
      tout_vld <= 1'b0;
      for (int i = 0; i < PHY_NUM; i++) timer_q[i] <= '0;
    end else begin
      tout_sel <= tout_d;
      tout_vld <= |tout_d;
      for (int i = 0; i < PHY_NUM; i++) begin
        if (finish && (grant_q == PTR_W'(i))) begin
          busy_q[i]  <= 1'b1;
          timer_q[i] <= reg_tout;
        end else if (busy_q[i]) begin
          if ((lnk.rx_done && lnk.rx_done_sel[i]) || (timer_q[i] == TOUT_W'(1))) begin
            busy_q[i]  <= 1'b0;
            timer_q[i] <= '0;
          end else if (timer_q[i] > TOUT_W'(1)) begin
            timer_q[i] <= timer_q[i] - 1'b1;
          end
        end
      end
    end
  end

`ifdef ALINK_AUTO_MASK_EN
  logic [PHY_NUM-1:0] auto_q;

  // Sticky disable of channels that have timed out
  always_ff @(posedge clk) begin
    if (clr) auto_q <= '0;
    else     auto_q <= auto_q | tout_d;
  end

  assign auto_mask = auto_q;
`else
  assign auto_mask = '0;
`endif

  for (genvar g = 0; g < PHY_NUM; g++) begin : g_tcnt
    assign timer_cnt[TOUT_W*g +: TOUT_W] = timer_q[g];
  end

  assign lnk.tx_phy_start = start_q;
  assign lnk.tx_phy_sel   = sel_q;
  assign reg_busy         = busy_q;
  assign cur_state        = state_q;

endmodule

// File: tb/tb_alink_dispatch.sv
// tb/tb_alink_dispatch.sv - randomized and directed bench for alink_dispatch against a behavioural model
module tb_alink_dispatch;
  localparam int N  = 4;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst, flush;
  logic [N-1:0] mask, busy, tsel, amask;
  logic [TW-1:0] tout;
  logic tvld;
  logic [TW*N-1:0] tcnt;
  logic [1:0] cst;

  logic [2:0] mask3, busy3, tsel3, amask3;
  logic [TW-1:0] tout3;
  logic tvld3;
  logic [TW*3-1:0] tcnt3;
  logic [1:0] cst3;

  alink_dispatch_if #(.PHY_NUM(N)) lk ();
  alink_dispatch_if #(.PHY_NUM(3)) lk3 ();

  alink_dispatch #(.PHY_NUM(N), .TOUT_W(TW), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .reg_flush(flush), .reg_mask(mask), .reg_tout(tout),
    .lnk(lk), .reg_busy(busy), .tout_vld(tvld), .tout_sel(tsel),
    .timer_cnt(tcnt), .auto_mask(amask), .cur_state(cst));

  alink_dispatch #(.PHY_NUM(3), .TOUT_W(TW), .PTR_W(2)) dut3 (
    .clk(clk), .rst(rst), .reg_flush(1'b0), .reg_mask(mask3), .reg_tout(tout3),
    .lnk(lk3), .reg_busy(busy3), .tout_vld(tvld3), .tout_sel(tsel3),
    .timer_cnt(tcnt3), .auto_mask(amask3), .cur_state(cst3));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0, auto_done = 0, auto3 = 0;
  logic [N-1:0] glog[$];
  logic [2:0]   glog3[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model of the 4-channel instance
  bit         m_send, m_start;
  int         m_grant, m_rr;
  bit [N-1:0] m_busy, m_auto, m_tsel, m_sel;
  int         m_tmr[N];

  always @(posedge clk) begin : mdl
    int pick;
    bit [N-1:0] ts;
    int setc;
    if (rst || flush) begin
      m_send = 0; m_start = 0; m_grant = 0; m_rr = 0;
      m_busy = 0; m_auto = 0; m_tsel = 0; m_sel = 0;
      for (int i = 0; i < N; i++) m_tmr[i] = 0;
    end else begin
      setc = -1; ts = 0; m_start = 0;
      if (!m_send) begin
        pick = -1;
        if (lk.tx_task_vld)
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (pick < 0 && !mask[c] && !m_busy[c] && !m_auto[c]) pick = c;
          end
        if (pick >= 0) begin
          m_send = 1; m_start = 1; m_grant = pick; m_sel = 0; m_sel[pick] = 1;
        end
      end else if (lk.tx_phy_done) begin
        setc = m_grant; m_rr = (m_grant + 1) % N; m_sel = 0; m_send = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (setc == i) begin
          m_busy[i] = 1; m_tmr[i] = int'(tout);
        end else if (m_busy[i]) begin
          if (lk.rx_done && lk.rx_done_sel[i]) begin
            m_busy[i] = 0; m_tmr[i] = 0;
          end else if (m_tmr[i] == 1) begin
            m_busy[i] = 0; m_tmr[i] = 0; ts[i] = 1;
          end else if (m_tmr[i] > 1) m_tmr[i] = m_tmr[i] - 1;
        end
      end
      m_tsel = ts;
`ifdef ALINK_AUTO_MASK_EN
      m_auto = m_auto | ts;
`endif
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("start", lk.tx_phy_start, m_start);
      chk("sel", lk.tx_phy_sel, m_sel);
      chk("busy", busy, m_busy);
      chk("tout_vld", tvld, m_tsel != 0);
      chk("tout_sel", tsel, m_tsel);
      chk("auto_mask", amask, m_auto);
      chk("state", cst, m_send ? 2'd1 : 2'd0);
      for (int i = 0; i < N; i++) chk("timer", tcnt[TW*i +: TW], m_tmr[i]);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (auto_done) lk.tx_phy_done = lk.tx_phy_start;
    if (auto3) lk3.tx_phy_done = lk3.tx_phy_start;
    if (lk.tx_phy_start) glog.push_back(lk.tx_phy_sel);
    if (lk3.tx_phy_start) glog3.push_back(lk3.tx_phy_sel);
    lk.rx_done = 0; lk.rx_done_sel = 0; lk3.rx_done = 0; lk3.rx_done_sel = 0;
    flush = 0;
  endtask

  task automatic do_flush(input logic [N-1:0] mk, input logic [TW-1:0] to);
    lk.tx_task_vld = 0; flush = 1; mask = mk; tout = to;
    tick();
    glog.delete();
  endtask

  task automatic grant_one();
    lk.tx_task_vld = 1;
    for (int t = 0; t < 20 && glog.size() == 0; t++) tick();
    lk.tx_task_vld = 0;
    chk("grant_seen", glog.size() > 0, 1);
    for (int t = 0; t < 20 && !busy[2]; t++) tick();
    chk("busy2_set", busy[2], 1);
  endtask

  initial begin
    rst = 1; flush = 0; mask = 0; tout = 0;
    lk.tx_task_vld = 0; lk.tx_phy_done = 0; lk.rx_done = 0; lk.rx_done_sel = 0;
    mask3 = 0; tout3 = 0;
    lk3.tx_task_vld = 0; lk3.tx_phy_done = 0; lk3.rx_done = 0; lk3.rx_done_sel = 0;
    repeat (3) tick();
    rst = 0; chk_en = 1;
    chk("rst_busy", busy, 0);
    chk("rst_sel", lk.tx_phy_sel, 0);
    chk("rst_state", cst, 0);
    chk("rst_timers", tcnt, 0);
    chk("rst_tout", tvld, 0);

    // all channels, no timeout: one grant per channel, in order
    auto_done = 1; lk.tx_task_vld = 1;
    repeat (20) tick();
    chk("A_count", glog.size(), 4);
    for (int i = 0; i < glog.size() && i < 4; i++) chk("A_grant", glog[i], 4'b0001 << i);
    chk("A_busy", busy, 4'hf);

    // masked channels 0 and 2
    lk.tx_task_vld = 0; tick();
    do_flush(4'b0101, 0);
    lk.tx_task_vld = 1;
    repeat (15) tick();
    chk("B_count", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("B_g0", glog[0], 4'b0010);
      chk("B_g1", glog[1], 4'b1000);
    end
    lk.rx_done = 1; lk.rx_done_sel = 4'b0010;
    repeat (8) tick();
    chk("B_count2", glog.size(), 3);
    if (glog.size() >= 3) chk("B_g2", glog[2], 4'b0010);

    // timeout on ch2 with reg_tout=5
    do_flush(4'b1011, 5);
    grant_one();
    for (int v = 5; v >= 1; v--) begin
      chk("C_timer", tcnt[TW*2 +: TW], v);
      chk("C_novld", tvld, 0);
      tick();
    end
    chk("C_tvld", tvld, 1);
    chk("C_tsel", tsel, 4'b0100);
    chk("C_busy", busy[2], 0);
    tick();
    glog.delete();
    lk.tx_task_vld = 1;
    repeat (10) tick();
    lk.tx_task_vld = 0;
`ifdef ALINK_AUTO_MASK_EN
    chk("C_auto", amask, 4'b0100);
    chk("C_nogrant", glog.size(), 0);
`else
    chk("C_regrant", glog.size() > 0, 1);
`endif
    tick();

    // report coinciding with timer==1 suppresses the timeout
    do_flush(4'b1011, 3);
    grant_one();
    chk("D_t3", tcnt[TW*2 +: TW], 3); tick();
    chk("D_t2", tcnt[TW*2 +: TW], 2); tick();
    chk("D_t1", tcnt[TW*2 +: TW], 1);
    lk.rx_done = 1; lk.rx_done_sel = 4'b0100;
    tick();
    chk("D_busy", busy[2], 0);
    chk("D_novld", tvld, 0);
    chk("D_timer", tcnt[TW*2 +: TW], 0);

    // flush in second SEND cycle
    do_flush(4'b0000, 0);
    lk.tx_task_vld = 1;
    for (int t = 0; t < 30 && busy != 4'b0011; t++) tick();
    chk("E_busy", busy, 4'b0011);
    auto_done = 0; lk.tx_phy_done = 0;
    for (int t = 0; t < 10 && !lk.tx_phy_start; t++) tick();
    chk("E_start", lk.tx_phy_start, 1);
    tick();
    flush = 1; lk.tx_task_vld = 0;
    tick();
    chk("E_state", cst, 0);
    chk("E_busy0", busy, 0);
    chk("E_timers", tcnt, 0);
    chk("E_sel", lk.tx_phy_sel, 0);
    lk.tx_phy_done = 1;
    tick();
    lk.tx_phy_done = 0;
    chk("E_late", busy, 0);
    glog.delete();
    auto_done = 1; lk.tx_task_vld = 1;
    repeat (6) tick();
    chk("E_next", glog.size() > 0 ? glog[0] : 4'b0, 4'b0001);

    // randomized traffic
    auto_done = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      lk.tx_task_vld = ($urandom % 4) != 0;
      lk.tx_phy_done = ($urandom % 3) == 0;
      if ($urandom % 4 == 0) begin
        lk.rx_done = 1; lk.rx_done_sel = 4'b0001 << ($urandom % 4);
      end
      if ($urandom % 50 == 0) mask = 4'($urandom);
      if ($urandom % 40 == 0) tout = 8'($urandom % 7);
      if ($urandom % 250 == 0) flush = 1;
    end
    lk.tx_task_vld = 0; lk.tx_phy_done = 0;

    // 3-channel instance: pointer wraps at 3
    auto3 = 1; lk3.tx_task_vld = 1;
    repeat (15) tick();
    chk("G_busy", busy3, 3'b111);
    lk3.rx_done = 1; lk3.rx_done_sel = 3'b111;
    repeat (15) tick();
    chk("G_count", glog3.size(), 6);
    for (int i = 0; i < glog3.size() && i < 6; i++) chk("G_grant", glog3[i], 3'b001 << (i % 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
